fifo_frame_reader: RTL and testbench



---
 rtl/fifo_frame_reader.sv | 67 ++++++
 tb/tb_fifo_frame_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains a byte FIFO, parses length-prefixed frames and
// streams payload bytes with sop/eop marks through a 2-entry output queue.
module fifo_frame_reader (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);
  typedef enum logic {HDR, PAY} state_t;
  state_t      state, state_n;
  logic        pend, first, pop, push, hdr_zero, hdr_load, wr;
  logic [1:0]  occ;
  logic [7:0]  rem;
  logic [9:0]  q [2];
  assign out_valid = occ != 2'd0;
  assign {out_data, out_sop, out_eop} = q[0];
  assign pop      = out_valid & out_ready;
  assign push     = pend & (state == PAY);
  assign hdr_zero = pend & (state == HDR) & (fifo_data == 8'd0);
  assign hdr_load = pend & (state == HDR) & (fifo_data != 8'd0);
  // Write slot after any same-cycle pop; occ=2 without pop never pushes.
  assign wr = occ[1] | (occ[0] & ~pop);
  // A read in flight already owns a queue slot, so count it with occupancy.
  assign fifo_rd = RSTn & ~fifo_empty & (({1'b0, occ} + {2'b0, pend} - {2'b0, pop}) < 3'd2);
  always_comb begin
    state_n = state;
    if (pend) state_n = (state == HDR) ? ((fifo_data != 8'd0) ? PAY : HDR)
                                       : ((rem == 8'd1) ? HDR : PAY);
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= HDR;
      pend      <= 1'b0;
      occ       <= 2'd0;
      rem       <= 8'd0;
      first     <= 1'b0;
      frame_cnt <= 16'd0;
      drop_cnt  <= 8'd0;
      q[0]      <= 10'd0;
      q[1]      <= 10'd0;
    end else begin
      state <= state_n;
      pend  <= fifo_rd;
      occ   <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) q[0] <= q[1];
      if (push) q[wr] <= {fifo_data, first, rem == 8'd1};
      if (hdr_zero) drop_cnt <= drop_cnt + 8'd1;
      if (hdr_load) begin
        rem   <= fifo_data;
        first <= 1'b1;
      end
      if (push) begin
        rem   <= rem - 8'd1;
        first <= 1'b0;
      end
      if (push && rem == 8'd1) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed scenarios against a behavioural 16-deep byte FIFO
// with one-cycle read latency; inputs change at posedge+1, outputs sampled at negedge.
module tb_fifo_frame_reader;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        fifo_empty, fifo_rd, out_sop, out_eop, out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  fifo_data = 8'd0;
  logic [7:0]  out_data, drop_cnt;
  logic [15:0] frame_cnt;
  logic [7:0]  mem [256];
  int          wr_ptr = 0, rd_ptr = 0, cyc = 0, rd_cnt = 0, rd_empty = 0;
  int          vec = 0, err = 0;
  logic [7:0]  rec_d [$];
  logic        rec_s [$], rec_e [$];
  int          rec_c [$];

  fifo_frame_reader dut (
    .CLK(CLK), .RSTn(RSTn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO model shares RSTn, so reset flushes any stale bytes.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= 8'd0;
    end else if (fifo_rd) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge CLK) begin
    if (fifo_rd) begin
      rd_cnt++;
      if (fifo_empty) rd_empty++;
    end
    if (out_valid && out_ready) begin
      rec_d.push_back(out_data);
      rec_s.push_back(out_sop);
      rec_e.push_back(out_eop);
      rec_c.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic reset_dut;
    @(posedge CLK); #1;
    RSTn = 1'b0;
    out_ready = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge CLK); #1;
    push_byte(8'h03);
    out_ready = 1'b1;
    #1;
    vec++; if (fifo_rd !== 1'b0) begin err++; $display("FAIL reset_fifo_rd got %b want 0", fifo_rd); end
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (out_data !== 8'h00) begin err++; $display("FAIL reset_out_data got %h want 00", out_data); end
    vec++; if ({out_sop, out_eop} !== 2'b00) begin err++; $display("FAIL reset_sop_eop got %b want 00", {out_sop, out_eop}); end
    vec++; if (frame_cnt !== 16'd0) begin err++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    vec++; if (drop_cnt !== 8'd0) begin err++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] ed [3];
    logic       es [3], ee [3];
    int base, rd_c, v_c;
    ed = '{8'hAA, 8'hBB, 8'hCC};
    es = '{1'b1, 1'b0, 1'b0};
    ee = '{1'b0, 1'b0, 1'b1};
    reset_dut;
    base = rec_d.size();
    out_ready = 1'b1;
    push_byte(8'h03); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    rd_c = -1; v_c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (fifo_rd && rd_c < 0) rd_c = cyc;
      if (out_valid && v_c < 0) v_c = cyc;
    end
    vec++; if (v_c - rd_c !== 3) begin err++; $display("FAIL basic_latency got %0d want 3", v_c - rd_c); end
    vec++; if (rec_d.size() - base !== 3) begin err++; $display("FAIL basic_count got %0d want 3", rec_d.size() - base); end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if ({rec_d[base+i], rec_s[base+i], rec_e[base+i]} !== {ed[i], es[i], ee[i]}) begin
        err++; $display("FAIL basic_byte%0d got %h/%b%b want %h/%b%b", i, rec_d[base+i], rec_s[base+i], rec_e[base+i], ed[i], es[i], ee[i]);
      end
    end
    vec++; if (rec_c[base+2] - rec_c[base] !== 2) begin err++; $display("FAIL basic_consecutive got span %0d want 2", rec_c[base+2] - rec_c[base]); end
    vec++; if (frame_cnt !== 16'd1) begin err++; $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_drop;
    int base;
    reset_dut;
    base = rec_d.size();
    out_ready = 1'b1;
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'h55);
    repeat (15) @(negedge CLK);
    vec++; if (rec_d.size() - base !== 1) begin err++; $display("FAIL drop_count got %0d want 1", rec_d.size() - base); end
    vec++; if ({rec_d[base], rec_s[base], rec_e[base]} !== {8'h55, 1'b1, 1'b1}) begin
      err++; $display("FAIL drop_byte got %h/%b%b want 55/11", rec_d[base], rec_s[base], rec_e[base]);
    end
    vec++; if (drop_cnt !== 8'd2) begin err++; $display("FAIL drop_cnt got %0d want 2", drop_cnt); end
    vec++; if (frame_cnt !== 16'd1) begin err++; $display("FAIL drop_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_backpressure;
    int base, r0, nvalid, bad;
    reset_dut;
    base = rec_d.size();
    r0 = rd_cnt;
    out_ready = 1'b0;
    push_byte(8'h05);
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    nvalid = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        nvalid++;
        if ({out_data, out_sop} !== {8'h11, 1'b1}) bad++;
      end
    end
    vec++; if (rd_cnt - r0 !== 3) begin err++; $display("FAIL bp_reads got %0d want 3", rd_cnt - r0); end
    vec++; if (nvalid !== 7) begin err++; $display("FAIL bp_valid_cycles got %0d want 7", nvalid); end
    vec++; if (bad !== 0) begin err++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    vec++; if ({out_valid, out_data} !== {1'b1, 8'h11}) begin err++; $display("FAIL bp_head got %b/%h want 1/11", out_valid, out_data); end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    repeat (12) @(negedge CLK);
    vec++; if (rec_d.size() - base !== 5) begin err++; $display("FAIL bp_count got %0d want 5", rec_d.size() - base); end
    for (int i = 0; i < 5; i++) begin
      vec++;
      if ({rec_d[base+i], rec_s[base+i], rec_e[base+i]} !== {8'h11 + 8'(i), i == 0, i == 4}) begin
        err++; $display("FAIL bp_byte%0d got %h/%b%b want %h/%b%b", i, rec_d[base+i], rec_s[base+i], rec_e[base+i], 8'h11 + 8'(i), i == 0, i == 4);
      end
    end
    vec++; if (rd_cnt - r0 !== 6) begin err++; $display("FAIL bp_total_reads got %0d want 6", rd_cnt - r0); end
    vec++; if (frame_cnt !== 16'd1) begin err++; $display("FAIL bp_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] src [64];
    int base, e0, idx, n;
    for (int f = 0; f < 4; f++) begin
      src[f*16] = 8'h0F;
      for (int j = 0; j < 15; j++) src[f*16+1+j] = 8'(j);
    end
    reset_dut;
    base = rec_d.size();
    e0 = rd_empty;
    out_ready = 1'b1;
    idx = 0;
    for (int t = 0; t < 200 && rec_d.size() < base + 60; t++) begin
      while (idx < 64 && wr_ptr - rd_ptr < 16) begin
        push_byte(src[idx]);
        idx++;
      end
      @(posedge CLK); #1;
    end
    repeat (4) @(negedge CLK);
    n = rec_d.size() - base;
    vec++; if (n !== 60) begin err++; $display("FAIL b2b_count got %0d want 60", n); end
    for (int i = 0; i < 60; i++) begin
      vec++;
      if ({rec_d[base+i], rec_s[base+i], rec_e[base+i]} !== {8'(i % 15), (i % 15) == 0, (i % 15) == 14}) begin
        err++; $display("FAIL b2b_byte%0d got %h/%b%b want %h/%b%b", i, rec_d[base+i], rec_s[base+i], rec_e[base+i], 8'(i % 15), (i % 15) == 0, (i % 15) == 14);
      end
    end
    vec++; if (rec_c[base+59] - rec_c[base] !== 62) begin err++; $display("FAIL b2b_span got %0d want 62", rec_c[base+59] - rec_c[base]); end
    vec++; if (rd_empty - e0 !== 0) begin err++; $display("FAIL b2b_rd_while_empty got %0d want 0", rd_empty - e0); end
    vec++; if (frame_cnt !== 16'd4) begin err++; $display("FAIL b2b_frame_cnt got %0d want 4", frame_cnt); end
  endtask

  task automatic test_reset_midframe;
    int base, t;
    reset_dut;
    base = rec_d.size();
    out_ready = 1'b1;
    push_byte(8'h04);
    for (int i = 0; i < 4; i++) push_byte(8'hA1 + 8'(i));
    t = 0;
    while (rec_d.size() < base + 2 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    vec++; if (rec_d.size() < base + 2) begin err++; $display("FAIL mid_wait got %0d bytes want 2", rec_d.size() - base); end
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    vec++; if ({out_valid, out_data, out_sop, out_eop} !== 11'd0) begin
      err++; $display("FAIL mid_reset_out got %b/%h/%b%b want 0/00/00", out_valid, out_data, out_sop, out_eop);
    end
    vec++; if (fifo_rd !== 1'b0) begin err++; $display("FAIL mid_reset_rd got %b want 0", fifo_rd); end
    vec++; if (frame_cnt !== 16'd0) begin err++; $display("FAIL mid_reset_frame_cnt got %0d want 0", frame_cnt); end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    base = rec_d.size();
    push_byte(8'h01); push_byte(8'h77);
    repeat (12) @(negedge CLK);
    vec++; if (rec_d.size() - base !== 1) begin err++; $display("FAIL mid_count got %0d want 1", rec_d.size() - base); end
    vec++; if ({rec_d[base], rec_s[base], rec_e[base]} !== {8'h77, 1'b1, 1'b1}) begin
      err++; $display("FAIL mid_byte got %h/%b%b want 77/11", rec_d[base], rec_s[base], rec_e[base]);
    end
    vec++; if (frame_cnt !== 16'd1) begin err++; $display("FAIL mid_frame_cnt got %0d want 1", frame_cnt); end
    vec++; if (drop_cnt !== 8'd0) begin err++; $display("FAIL mid_drop_cnt got %0d want 0", drop_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_drop;
    test_backpressure;
    test_back_to_back;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
